// File: rtl/vex_issue_sequencer_if.sv
// Instruction-in / uop-out bus between the rename queue, the issue sequencer and vex.
// slave is the sequencer's view; master is the view of whatever drives instructions and consumes uops.
interface vex_issue_sequencer_if #(
    parameter int VECTOR_REGISTERS   = 32,
    parameter int VECTOR_LANES       = 8,
    parameter int MAX_VL             = 64,
    parameter int VECTOR_TICKET_BITS = 5
);
    localparam int REG_W = $clog2(VECTOR_REGISTERS);
    localparam int VL_W  = $clog2(MAX_VL) + 1;

    logic                          instr_valid_i;
    logic                          instr_ready_o;
    logic [REG_W-1:0]              instr_dst_i;
    logic [REG_W-1:0]              instr_src1_i;
    logic [REG_W-1:0]              instr_src2_i;
    logic [VL_W-1:0]               instr_vl_i;
    logic                          instr_is_fp_i;
    logic                          instr_is_rdc_i;

    logic                          uop_valid_o;
    logic                          vex_ready_i;
    logic [VECTOR_LANES-1:0]       uop_lane_valid_o;
    logic [REG_W-1:0]              uop_dst_o;
    logic [REG_W-1:0]              uop_src1_o;
    logic [REG_W-1:0]              uop_src2_o;
    logic                          uop_head_o;
    logic                          uop_end_o;
    logic                          uop_is_rdc_o;
    logic [VECTOR_TICKET_BITS-1:0] uop_ticket_o;

    modport slave (
        input  instr_valid_i, instr_dst_i, instr_src1_i, instr_src2_i, instr_vl_i,
               instr_is_fp_i, instr_is_rdc_i, vex_ready_i,
        output instr_ready_o, uop_valid_o, uop_lane_valid_o, uop_dst_o, uop_src1_o,
               uop_src2_o, uop_head_o, uop_end_o, uop_is_rdc_o, uop_ticket_o
    );

    modport master (
        output instr_valid_i, instr_dst_i, instr_src1_i, instr_src2_i, instr_vl_i,
               instr_is_fp_i, instr_is_rdc_i, vex_ready_i,
        input  instr_ready_o, uop_valid_o, uop_lane_valid_o, uop_dst_o, uop_src1_o,
               uop_src2_o, uop_head_o, uop_end_o, uop_is_rdc_o, uop_ticket_o
    );
endinterface

// File: rtl/vex_issue_sequencer.sv
// Splits one vector instruction at a time into VECTOR_LANES-wide uops for vex, serialising
// FP instructions around the FP lanes and bounding the number of instructions in flight.
module vex_issue_sequencer #(
    parameter int VECTOR_REGISTERS   = 32,
    parameter int VECTOR_LANES       = 8,
    parameter int MAX_VL             = 64,
    parameter int VECTOR_TICKET_BITS = 5,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vex_issue_sequencer_if.slave bus,
    input  logic                 fp_done_i,
    input  logic                 wb_done_i,
    output logic                 busy_o
);
    localparam int REG_W = $clog2(VECTOR_REGISTERS);
    localparam int VL_W  = $clog2(MAX_VL) + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, ISSUE, FP_DRAIN} state_e;

    state_e                        state_q, state_d;
    logic [REG_W-1:0]              dst_q, dst_d;
    logic [REG_W-1:0]              src1_q, src1_d;
    logic [REG_W-1:0]              src2_q, src2_d;
    logic                          is_fp_q, is_fp_d;
    logic                          is_rdc_q, is_rdc_d;
    logic                          head_q, head_d;
    logic [VL_W-1:0]               rem_q, rem_d;
    logic [VECTOR_TICKET_BITS-1:0] ticket_q, ticket_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic instr_ready;
    logic accept;
    logic issuing;
    logic last_uop;
    logic xfer;
    logic cnt_inc;
    logic cnt_dec;

    // Register indices wrap at VECTOR_REGISTERS, which need not be a power of two.
    function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] r);
        if (int'(r) == VECTOR_REGISTERS - 1) return '0;
        return r + 1'b1;
    endfunction

    function automatic logic [VECTOR_LANES-1:0] lane_mask(input logic [VL_W-1:0] rem);
        logic [VECTOR_LANES-1:0] m;
        for (int i = 0; i < VECTOR_LANES; i++) m[i] = (int'(rem) > i);
        return m;
    endfunction

    assign instr_ready = (state_q == IDLE) && (int'(count_q) < MAX_OUTSTANDING);
    assign accept      = bus.instr_valid_i && instr_ready;
    assign issuing     = (state_q == ISSUE);
    assign last_uop    = (int'(rem_q) <= VECTOR_LANES);
    assign xfer        = issuing && bus.vex_ready_i;
    assign cnt_inc     = xfer && last_uop;
    assign cnt_dec     = wb_done_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (cnt_inc && !cnt_dec) count_d = count_q + 1'b1;
        else if (!cnt_inc && cnt_dec) count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        is_fp_d  = is_fp_q;
        is_rdc_d = is_rdc_q;
        head_d   = head_q;
        rem_d    = rem_q;
        ticket_d = ticket_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dst_d    = bus.instr_dst_i;
                    src1_d   = bus.instr_src1_i;
                    src2_d   = bus.instr_src2_i;
                    is_fp_d  = bus.instr_is_fp_i;
                    is_rdc_d = bus.instr_is_rdc_i;
                    rem_d    = bus.instr_vl_i;
                    head_d   = (bus.instr_vl_i != '0);
                    // A zero-length instruction is swallowed: no uop, no ticket, no count.
                    if (bus.instr_vl_i != '0) begin
                        state_d = (bus.instr_is_fp_i && !fp_done_i) ? WAIT_IDLE : ISSUE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (fp_done_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (xfer) begin
                    head_d = 1'b0;
                    dst_d  = next_reg(dst_q);
                    src1_d = next_reg(src1_q);
                    src2_d = next_reg(src2_q);
                    if (last_uop) begin
                        rem_d    = '0;
                        ticket_d = ticket_q + 1'b1;
                        state_d  = is_fp_q ? FP_DRAIN : IDLE;
                    end else begin
                        rem_d = rem_q - VL_W'(VECTOR_LANES);
                    end
                end
            end
            FP_DRAIN: begin
                if (fp_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            is_fp_q  <= 1'b0;
            is_rdc_q <= 1'b0;
            head_q   <= 1'b0;
            rem_q    <= '0;
            ticket_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            is_fp_q  <= is_fp_d;
            is_rdc_q <= is_rdc_d;
            head_q   <= head_d;
            rem_q    <= rem_d;
            ticket_q <= ticket_d;
            count_q  <= count_d;
        end
    end

    // Uop fields are decoded only from registers, so they hold steady while vex stalls.
    assign bus.instr_ready_o    = instr_ready;
    assign bus.uop_valid_o      = issuing;
    assign bus.uop_lane_valid_o = issuing ? lane_mask(rem_q) : '0;
    assign bus.uop_dst_o        = dst_q;
    assign bus.uop_src1_o       = src1_q;
    assign bus.uop_src2_o       = src2_q;
    assign bus.uop_head_o       = issuing && head_q;
    assign bus.uop_end_o        = issuing && last_uop;
    assign bus.uop_is_rdc_o     = issuing && is_rdc_q;
    assign bus.uop_ticket_o     = ticket_q;
    assign busy_o               = (state_q != IDLE) || (count_q != '0);
endmodule
